conv1d_mac: RTL

//  Downstream consumer of the 5-tap 12-bit pixel window shift buffer in the convolution_2 datapath.
//  - Tracks window fill.
//  - Multiplies each tap by a programmable signed coefficient.
//  - Sums, rounds, right-shifts and saturates the result to an unsigned pixel.
//  - Emits one result per full window under a valid/ready handshake.
//  - Drives back-pressure so upstream can freeze the window buffer.

---
 rtl/conv1d_mac.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/conv1d_mac.sv
// rtl/conv1d_mac.sv - 5-tap signed-coefficient MAC with round/shift/saturate and valid/ready output
// Consumes the pixel window shift buffer: counts window fill, launches one
// multiply-accumulate per full window, and back-pressures upstream via stall.
module conv1d_mac #(
   parameter int DW    = 12,
   parameter int TAPS  = 5,
   parameter int CW    = 8,
   parameter int SHIFT = 4,
   parameter int OW    = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 shift,
   input  logic                 flush,
   input  logic [DW*TAPS-1:0]   win_in,
   input  logic                 coef_we,
   input  logic [2:0]           coef_idx,
   input  logic [CW-1:0]        coef_data,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [OW-1:0]        out_data,
   output logic                 stall
);

   localparam int PW = DW + CW + 1;
   localparam int SW = PW + 3;
   localparam int FW = $clog2(TAPS + 1);

   logic [FW-1:0]         fill;
   logic [FW-1:0]         fill_next;
   logic                  launch;
   logic                  acc;
   logic                  v1;
   logic                  v2;
   logic signed [CW-1:0]  coef [TAPS];
   logic signed [PW-1:0]  p_d  [TAPS];
   logic signed [PW-1:0]  p_q  [TAPS];
   logic signed [SW-1:0]  s_d;
   logic signed [SW-1:0]  s_q;
   logic signed [SW-1:0]  rnd;
   logic signed [SW-1:0]  r;
   logic [OW-1:0]         r_sat;

   // A pending result that downstream refuses freezes the whole datapath.
   assign stall = out_valid & ~out_ready;
   assign acc   = en & shift & ~stall;

   // Fill count saturates at TAPS: once full, every accepted shift is a new window.
   always_comb begin
      fill_next = fill;
      if (acc && (fill != FW'(TAPS))) begin
         fill_next = fill + 1'b1;
      end
   end

   // Fill and launch tracking; launch delays sampling until the buffer has shifted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill   <= '0;
         launch <= 1'b0;
      end else if (flush) begin
         fill   <= '0;
         launch <= 1'b0;
      end else begin
         fill <= fill_next;
         if (!stall) begin
            launch <= acc && (fill_next == FW'(TAPS));
         end
      end
   end

   // Coefficient bank; out-of-range indices are dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < TAPS; k++) begin
            coef[k] <= '0;
         end
      end else if (coef_we && ({29'd0, coef_idx} < 32'(TAPS))) begin
         coef[coef_idx] <= $signed(coef_data);
      end
   end

   // Per-tap signed products: pixel zero-extended, coefficient sign-extended.
   always_comb begin
      for (int k = 0; k < TAPS; k++) begin
         p_d[k] = $signed({{CW{1'b0}}, 1'b0, win_in[DW*k +: DW]})
                * $signed({{(PW-CW){coef[k][CW-1]}}, coef[k]});
      end
   end

   // Adder tree with headroom so up to 8 taps cannot overflow.
   always_comb begin
      s_d = '0;
      for (int k = 0; k < TAPS; k++) begin
         s_d = s_d + {{(SW-PW){p_q[k][PW-1]}}, p_q[k]};
      end
   end

   // Round-half-up, arithmetic shift, then clamp to the unsigned output range.
   always_comb begin
      rnd = s_q + SW'(1 << (SHIFT - 1));
      r   = rnd >>> SHIFT;
      if (r[SW-1]) begin
         r_sat = '0;
      end else if (|r[SW-2:OW]) begin
         r_sat = '1;
      end else begin
         r_sat = r[OW-1:0];
      end
   end

   // Three-stage pipeline: products, sum, normalised output; all hold while stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         s_q       <= '0;
         for (int k = 0; k < TAPS; k++) begin
            p_q[k] <= '0;
         end
      end else if (flush) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
      end else if (!stall) begin
         v1 <= launch;
         if (launch) begin
            for (int k = 0; k < TAPS; k++) begin
               p_q[k] <= p_d[k];
            end
         end
         v2 <= v1;
         if (v1) begin
            s_q <= s_d;
         end
         out_valid <= v2;
         if (v2) begin
            out_data <= r_sat;
         end
      end
   end

endmodule
